// File: rtl/log2_frac_seq.sv
// Sequential base-2 logarithm with fractional bits.
// The integer part comes from a leading-one detect on the operand. The
// fractional part is produced one bit per cycle, MSB first, by repeatedly
// squaring the normalised mantissa. Operands and results move on
// valid/ready handshakes.
module log2_frac_seq #(
    parameter int width     = 16,  // operand width, >= 2
    parameter int frac_bits = 4,   // fractional result bits, >= 1
    parameter int speed     = 1    // LOD prefix: 0 serial, 1 Brent-Kung, 2 Sklansky
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  logic [width-1:0]                   A_i,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [$clog2(width)+frac_bits-1:0] Z_o,
    output logic                               zero_o
);

    localparam int ew = $clog2(width);
    localparam int cw = $clog2(frac_bits + 1);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t               state, state_next;
    logic [width-1:0]     mant;
    logic [frac_bits-1:0] frac;
    logic [cw-1:0]        cnt;
    logic [ew-1:0]        e_q;

    // Leading-one detect signals: rev is the operand bit-reversed so that a
    // prefix OR from index 0 marks everything at or below the leading one.
    logic [width-1:0]     rev;
    logic [width-1:0]     pre;
    logic [ew-1:0]        lead_pos;   // distance of the leading one from the MSB
    logic [ew-1:0]        e_c;
    logic [width-1:0]     mant_init;

    logic [2*width-1:0]   prod;
    logic                 sq_bit;
    logic [width-1:0]     mant_next;
    logic [frac_bits-1:0] frac_next;
    logic                 last_bit;
    logic                 unused_prod_lsb;

    // Prefix OR over the reversed operand; the tree shape is selected by speed
    // and every shape gives the same result.
    always_comb begin
        for (int j = 0; j < width; j++) begin
            rev[j] = A_i[width-1-j];
        end
        pre = rev;
        if (speed == 0) begin
            for (int j = 1; j < width; j++) begin
                pre[j] = pre[j] | pre[j-1];
            end
        end else if (speed == 2) begin
            for (int s = 0; (1 << s) < width; s++) begin
                for (int j = 0; j < width; j++) begin
                    if (((j >> s) & 1) == 1) begin
                        pre[j] = pre[j] | pre[((j >> s) << s) - 1];
                    end
                end
            end
        end else begin
            for (int s = 0; (1 << s) < width; s++) begin
                for (int j = 0; j < width; j++) begin
                    if (((j + 1) % (2 << s)) == 0) begin
                        pre[j] = pre[j] | pre[j - (1 << s)];
                    end
                end
            end
            for (int s = $clog2(width) - 2; s >= 0; s--) begin
                for (int j = 0; j < width; j++) begin
                    if (j >= (2 << s) && ((j + 1) % (2 << s)) == (1 << s)) begin
                        pre[j] = pre[j] | pre[j - (1 << s)];
                    end
                end
            end
        end
    end

    // Encode the first set prefix bit into a shift distance and exponent.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        lead_pos = '0;
        for (int j = 0; j < width; j++) begin
            if (pre[j] && (j == 0 || !pre[j-1])) begin
                lead_pos = lead_pos | ew'(j);
            end
        end
        e_c       = ew'(width - 1) - lead_pos;
        mant_init = A_i << lead_pos;
    end

    // One squaring step: the product MSB is the next fractional bit and
    // selects which window of the product renormalises the mantissa.
    always_comb begin
        prod            = {{width{1'b0}}, mant} * {{width{1'b0}}, mant};
        sq_bit          = prod[2*width-1];
        mant_next       = sq_bit ? prod[2*width-1:width] : prod[2*width-2:width-1];
        frac_next       = (frac << 1) | frac_bits'(sq_bit);
        last_bit        = (cnt == cw'(frac_bits - 1));
        unused_prod_lsb = ^prod[width-2:0];
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next  = state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    state_next = (A_i == '0) ? DONE : ITER;
                end
            end
            ITER: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, fractional iteration and result registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the datapath is reset too, so an aborted operation leaves
            // nothing behind and Z_o reads zero straight out of reset.
            mant   <= '0;
            frac   <= '0;
            cnt    <= '0;
            e_q    <= '0;
            Z_o    <= '0;
            zero_o <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        mant <= mant_init;
                        frac <= '0;
                        cnt  <= '0;
                        e_q  <= e_c;
                        if (A_i == '0) begin
                            zero_o <= 1'b1;
                            Z_o    <= '0;
                        end else begin
                            zero_o <= 1'b0;
                        end
                    end
                end
                ITER: begin
                    mant <= mant_next;
                    frac <= frac_next;
                    cnt  <= cnt + cw'(1);
                    if (last_bit) begin
                        Z_o <= {e_q, frac_next};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/log2_frac_seq.md
Name: log2_frac_seq

Overview:
Sequential base-2 logarithm unit with fractional output bits.
- Integer part: floor(log2 A), from a leading-one detect plus encode (same algorithm as the existing combinational Log2).
- Fractional part: FRAC_BITS bits by iterative mantissa squaring, one bit per cycle.
- Sits between producer and consumer stages on valid/ready handshakes.
- Serves as the log front end for fixed-point normalisation and dB-scale datapaths.

Parameters:
- width, 16: operand width; must be ≥ 2.
- frac_bits, 4: number of fractional result bits; must be ≥ 1.
- speed, 1: leading-one-detect prefix structure; 0 = serial, 1 = Brent-Kung, 2 = Sklansky. Does not change function.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  operand valid
- in_ready_o  out  1  unit can accept an operand
- A_i  in  width  unsigned operand
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- Z_o  out  $clog2(width)+frac_bits  result, unsigned Q($clog2(width)).(frac_bits)
- zero_o  out  1  operand was 0; log undefined

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni.
- Reset values: state=IDLE, out_valid_o=0, Z_o=0, zero_o=0, internal mantissa/count=0. in_ready_o=1 once reset is released.
- FSM states: IDLE, ITER, DONE. in_ready_o = (state==IDLE), combinational. out_valid_o = (state==DONE).
- IDLE:
  - On in_valid_i && in_ready_o, capture A_i.
  - e = floor(log2 A) is computed combinationally in the accept cycle.
  - M = A << (width-1-e), giving Q1.(width-1) with M[width-1]=1.
  - frac register cleared, count=0.
  - If A_i==0: zero_o<=1, Z_o<=0, go DONE.
  - Otherwise: zero_o<=0, go ITER.
- ITER, one fractional bit per cycle, MSB first:
  - P = M*M, 2*width bits, Q2.(2*width-2).
  - If P[2*width-1]=1: bit=1, M<=P[2*width-1:width].
  - Else: bit=0, M<=P[2*width-2:width-1].
  - Truncation only, no rounding. Bench model must use identical truncation.
  - Shift bit into frac; count++.
  - When count reaches frac_bits-1 with the last bit produced: load Z_o={e,frac}, go DONE.
- DONE:
  - Z_o and zero_o held stable while out_valid_o=1 && !out_ready_i.
  - On out_ready_i, go IDLE.
  - No new operand is accepted in the same cycle; in_ready_o rises the following cycle.
- Latency, accept edge to out_valid_o:
  - Nonzero operand: frac_bits+1 cycles.
  - Zero operand: 1 cycle.
- Throughput: one result per frac_bits+2 cycles with out_ready_i held high; one result per 2 cycles for zero operands.
- in_valid_i while not ready: ignored. The producer must hold A_i; nothing is captured.
- Operand A=2^k: M=1.0 exactly, so all fractional bits are 0 and Z_o = k<<frac_bits.
- Z_o keeps its last value in IDLE/ITER. Only out_valid_o qualifies it.
- Reset asserted mid-ITER or DONE: the operation is aborted and all state returns to reset values. No result is emitted after release.
- Multiplier: a full width×width product per cycle. Synthesis may retime it, but cycle behaviour must not change.

Test Plan:
All cases use width=16, frac_bits=4; Z_o is 8 bits.
1. A_i=0x0016 (22), out_ready_i=1 → out_valid_o 5 cycles after accept; Z_o=0x47 (4.4375); zero_o=0.
2. A_i=0x8000 → Z_o=0xF0. A_i=0x0001 → Z_o=0x00. A_i=0xFFFF → Z_o=0xFF. zero_o=0 in all three.
3. A_i=0x0000 → out_valid_o one cycle after accept; zero_o=1; Z_o=0x00. Next operand A_i=0x0004 → Z_o=0x20, zero_o=0.
4. Backpressure: A_i=0x0016, out_ready_i=0 for 6 cycles after out_valid_o → Z_o=0x47 and out_valid_o stable; in_ready_o=0 throughout. A second in_valid_i pulse is not captured. Release → in_ready_o=1 next cycle.
5. Reset: accept A_i=0x1234, assert rst_ni=0 during ITER (2 cycles after accept) → out_valid_o=0 and Z_o=0 immediately (asynchronous). After release, in_ready_o=1 and no result appears.
6. Random regression: 10k operands with random in_valid_i/out_ready_i gaps, repeated for speed=0,1,2 → all Z_o match the truncating squaring model bit-exactly; one result per accepted operand, in order.
